// File: rtl/k10_dbg_pkg.sv
// Shared constants and state encoding for the UART-to-AXI-Lite debug bridge.
package k10_dbg_pkg;

    localparam logic [7:0] CMD_WR   = 8'h57;
    localparam logic [7:0] CMD_RD   = 8'h52;
    localparam logic [5:0] RSP_BASE = 6'b101000;

    // IDLE wait cmd | ADDR collect 4 addr bytes | DATA collect 4 data bytes
    // AXI_WR/AXI_RD bus transaction in flight | RESP stream reply bytes
    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        AXI_WR,
        AXI_RD,
        RESP
    } dbg_state_e;

    function automatic logic [7:0] rsp_status(input logic [1:0] resp);
        return {RSP_BASE, resp};
    endfunction

endpackage

// File: rtl/k10_uart_phy.sv
// 8N1 UART byte engines: oversampling-free RX (mid-bit sampling) and gapless TX.
module k10_uart_phy #(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_uart_rx,
    output logic       o_uart_tx,
    input  logic [7:0] i_byte,
    input  logic       i_valid,
    output logic       o_ready,
    output logic [7:0] o_byte,
    output logic       o_valid,
    output logic       o_frame_err
);

    localparam int unsigned   CW      = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] DIV_M1  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'((BAUD_DIV >> 1) - 1);

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    localparam logic [2:0] RX_BREAK = 3'd4;

    logic          r_rx_meta;
    logic          r_rx_sync;
    logic [2:0]    r_rx_state;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_sh;
    logic          w_rx_tick;

    logic [9:0]    r_tx_sh;
    logic [CW-1:0] r_tx_cnt;
    logic [3:0]    r_tx_bits;
    logic          r_tx_busy;
    logic          w_tx_last;

    assign w_rx_tick = (r_rx_cnt == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_sh    <= '0;
        end else begin
            r_rx_meta <= i_uart_rx;
            r_rx_sync <= r_rx_meta;
            case (r_rx_state)
                RX_IDLE: begin
                    if (!r_rx_sync) begin
                        r_rx_cnt   <= HALF_M1;
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (w_rx_tick) begin
                        if (!r_rx_sync) begin
                            r_rx_cnt   <= DIV_M1;
                            r_rx_bit   <= '0;
                            r_rx_state <= RX_DATA;
                        end else begin
                            r_rx_state <= RX_IDLE;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt - CW'(1);
                    end
                end
                RX_DATA: begin
                    if (w_rx_tick) begin
                        r_rx_sh  <= {r_rx_sync, r_rx_sh[7:1]};
                        r_rx_cnt <= DIV_M1;
                        if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
                        else                  r_rx_bit   <= r_rx_bit + 3'd1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt - CW'(1);
                    end
                end
                RX_STOP: begin
                    if (w_rx_tick) r_rx_state <= r_rx_sync ? RX_IDLE : RX_BREAK;
                    else           r_rx_cnt   <= r_rx_cnt - CW'(1);
                end
                // A low stop bit may be a line break; re-arm only once the line is idle again.
                RX_BREAK: begin
                    if (r_rx_sync) r_rx_state <= RX_IDLE;
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    assign o_byte      = r_rx_sh;
    assign o_valid     = (r_rx_state == RX_STOP) && w_rx_tick && r_rx_sync;
    assign o_frame_err = (r_rx_state == RX_STOP) && w_rx_tick && !r_rx_sync;

    // Accepting in the final stop-bit cycle lets the next start bit follow with no gap.
    assign w_tx_last = r_tx_busy && (r_tx_cnt == '0) && (r_tx_bits == 4'd1);
    assign o_ready   = !r_tx_busy || w_tx_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_sh   <= '1;
            r_tx_cnt  <= '0;
            r_tx_bits <= '0;
            r_tx_busy <= 1'b0;
        end else if (i_valid && o_ready) begin
            r_tx_sh   <= {1'b1, i_byte, 1'b0};
            r_tx_cnt  <= DIV_M1;
            r_tx_bits <= 4'd10;
            r_tx_busy <= 1'b1;
        end else if (r_tx_busy) begin
            if (r_tx_cnt == '0) begin
                if (r_tx_bits == 4'd1) begin
                    r_tx_busy <= 1'b0;
                    r_tx_sh   <= '1;
                end else begin
                    r_tx_sh   <= {1'b1, r_tx_sh[9:1]};
                    r_tx_bits <= r_tx_bits - 4'd1;
                    r_tx_cnt  <= DIV_M1;
                end
            end else begin
                r_tx_cnt <= r_tx_cnt - CW'(1);
            end
        end
    end

    assign o_uart_tx = r_tx_sh[0];

endmodule

// File: rtl/k10_uart_dbg_bridge.sv
// UART debug bridge: parses byte frames from a host and issues single AXI4-Lite
// reads/writes as a bus master, returning status and read data over UART.
module k10_uart_dbg_bridge
    import k10_dbg_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_uart_rx,
    output logic        o_uart_tx,
    output logic [31:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] m_axi_araddr,
    output logic [2:0]  m_axi_arprot,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic        o_busy
);

    localparam int unsigned   BAUD_DIV = CLK_FREQ_HZ / BAUD;
    localparam int unsigned   TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYC - 1);

    logic [7:0] w_rx_byte;
    logic       w_rx_valid;
    logic       w_rx_err;
    logic [7:0] w_tx_byte;
    logic       w_tx_valid;
    logic       w_tx_ready;
    logic       w_aw_done;
    logic       w_w_done;

    dbg_state_e    r_state;
    logic          r_is_wr;
    logic [1:0]    r_byte_cnt;
    logic [23:0]   r_sh;
    logic [31:2]   r_addr;
    logic [31:0]   r_data;
    logic [1:0]    r_resp;
    logic [2:0]    r_rsp_idx;
    logic [2:0]    r_rsp_last;
    logic [TW-1:0] r_to_cnt;
    logic          r_awvalid;
    logic          r_wvalid;
    logic          r_bready;
    logic          r_arvalid;
    logic          r_rready;

    k10_uart_phy #(
        .BAUD_DIV (BAUD_DIV)
    ) u_phy (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_uart_rx   (i_uart_rx),
        .o_uart_tx   (o_uart_tx),
        .i_byte      (w_tx_byte),
        .i_valid     (w_tx_valid),
        .o_ready     (w_tx_ready),
        .o_byte      (w_rx_byte),
        .o_valid     (w_rx_valid),
        .o_frame_err (w_rx_err)
    );

    assign w_tx_valid = (r_state == RESP);

    always_comb begin
        w_tx_byte = rsp_status(r_resp);
        case (r_rsp_idx)
            3'd1:    w_tx_byte = r_data[7:0];
            3'd2:    w_tx_byte = r_data[15:8];
            3'd3:    w_tx_byte = r_data[23:16];
            3'd4:    w_tx_byte = r_data[31:24];
            default: w_tx_byte = rsp_status(r_resp);
        endcase
    end

    assign w_aw_done = !r_awvalid || m_axi_awready;
    assign w_w_done  = !r_wvalid  || m_axi_wready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_is_wr    <= 1'b0;
            r_byte_cnt <= '0;
            r_sh       <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_resp     <= '0;
            r_rsp_idx  <= '0;
            r_rsp_last <= '0;
            r_to_cnt   <= '0;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_bready   <= 1'b0;
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_to_cnt   <= TO_LOAD;
                    r_byte_cnt <= '0;
                    if (w_rx_valid && (w_rx_byte == CMD_WR || w_rx_byte == CMD_RD)) begin
                        r_is_wr <= (w_rx_byte == CMD_WR);
                        r_state <= ADDR;
                    end
                end
                ADDR, DATA: begin
                    if (w_rx_err) begin
                        r_state <= IDLE;
                    end else if (w_rx_valid) begin
                        r_to_cnt   <= TO_LOAD;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_sh       <= {w_rx_byte, r_sh[23:8]};
                        if (r_byte_cnt == 2'd3) begin
                            if (r_state == DATA) begin
                                r_data    <= {w_rx_byte, r_sh};
                                r_awvalid <= 1'b1;
                                r_wvalid  <= 1'b1;
                                r_state   <= AXI_WR;
                            end else begin
                                r_addr <= {w_rx_byte, r_sh[23:2]};
                                if (r_is_wr) begin
                                    r_state <= DATA;
                                end else begin
                                    r_arvalid <= 1'b1;
                                    r_state   <= AXI_RD;
                                end
                            end
                        end
                    end else if (r_to_cnt == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt - TW'(1);
                    end
                end
                AXI_WR: begin
                    if (r_awvalid && m_axi_awready) r_awvalid <= 1'b0;
                    if (r_wvalid && m_axi_wready)   r_wvalid  <= 1'b0;
                    if (!r_bready && w_aw_done && w_w_done) r_bready <= 1'b1;
                    if (r_bready && m_axi_bvalid) begin
                        r_bready   <= 1'b0;
                        r_resp     <= m_axi_bresp;
                        r_rsp_idx  <= '0;
                        r_rsp_last <= 3'd0;
                        r_state    <= RESP;
                    end
                end
                AXI_RD: begin
                    if (r_arvalid && m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                    end
                    if (r_rready && m_axi_rvalid) begin
                        r_rready   <= 1'b0;
                        r_resp     <= m_axi_rresp;
                        r_data     <= m_axi_rdata;
                        r_rsp_idx  <= '0;
                        r_rsp_last <= 3'd4;
                        r_state    <= RESP;
                    end
                end
                RESP: begin
                    if (w_tx_ready) begin
                        if (r_rsp_idx == r_rsp_last) r_state   <= IDLE;
                        else                         r_rsp_idx <= r_rsp_idx + 3'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign m_axi_awaddr  = {r_addr, 2'b00};
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_data;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
    assign m_axi_araddr  = {r_addr, 2'b00};
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;
    assign o_busy        = (r_state != IDLE);

endmodule

// File: tb/tb_k10_uart_dbg_bridge.sv
// Self-checking bench for the UART debug bridge, run at a reduced baud divisor.
module tb_k10_uart_dbg_bridge;

    localparam int DIV = 8;
    localparam int TO  = 300;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        tx;
    logic [31:0] awaddr, wdata, araddr;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready, busy;

    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = 2'b00, rresp = 2'b00;
    logic [31:0] rdata = '0;

    int          aw_delay = 0, w_delay = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = '0;

    bit hs_aw, hs_w, hs_b, hs_ar, hs_r;
    logic [31:0] exp_aw[$], exp_w[$], exp_ar[$];
    logic [7:0]  exp_tx[$];
    int          tx_start[$];
    int          checks = 0, failures = 0;
    int          cyc = 0;

    k10_uart_dbg_bridge #(
        .CLK_FREQ_HZ (1_000_000),
        .BAUD        (125_000),
        .TIMEOUT_CYC (TO)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_uart_rx     (rx),
        .o_uart_tx     (tx),
        .m_axi_awaddr  (awaddr),
        .m_axi_awprot  (awprot),
        .m_axi_awvalid (awvalid),
        .m_axi_awready (awready),
        .m_axi_wdata   (wdata),
        .m_axi_wstrb   (wstrb),
        .m_axi_wvalid  (wvalid),
        .m_axi_wready  (wready),
        .m_axi_bresp   (bresp),
        .m_axi_bvalid  (bvalid),
        .m_axi_bready  (bready),
        .m_axi_araddr  (araddr),
        .m_axi_arprot  (arprot),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_rdata   (rdata),
        .m_axi_rresp   (rresp),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (rready),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Handshake monitor: sampled mid-cycle, so valid&ready here means a transfer at the next edge.
    initial begin
        logic        prev_awv, prev_wv;
        logic [31:0] prev_awa, prev_wd, e;
        prev_awv = 1'b0;
        prev_wv  = 1'b0;
        forever begin
            @(negedge clk);
            hs_aw = rst_n && awvalid && awready;
            hs_w  = rst_n && wvalid && wready;
            hs_b  = rst_n && bvalid && bready;
            hs_ar = rst_n && arvalid && arready;
            hs_r  = rst_n && rvalid && rready;
            if (rst_n) begin
                if (awvalid && prev_awv) begin
                    checks++;
                    if (awaddr !== prev_awa) begin
                        failures++;
                        $display("FAIL aw_stable awaddr=%h was=%h", awaddr, prev_awa);
                    end
                end
                if (wvalid && prev_wv) begin
                    checks++;
                    if (wdata !== prev_wd) begin
                        failures++;
                        $display("FAIL w_stable wdata=%h was=%h", wdata, prev_wd);
                    end
                end
                if (hs_aw) begin
                    checks++;
                    if (exp_aw.size() == 0) begin
                        failures++;
                        $display("FAIL aw_unexpected awaddr=%h", awaddr);
                    end else begin
                        e = exp_aw.pop_front();
                        if (awaddr !== e || awprot !== 3'b000) begin
                            failures++;
                            $display("FAIL aw_addr got=%h/%0d expected=%h/0", awaddr, awprot, e);
                        end
                    end
                end
                if (hs_w) begin
                    checks++;
                    if (exp_w.size() == 0) begin
                        failures++;
                        $display("FAIL w_unexpected wdata=%h", wdata);
                    end else begin
                        e = exp_w.pop_front();
                        if (wdata !== e || wstrb !== 4'hF) begin
                            failures++;
                            $display("FAIL w_data got=%h/%h expected=%h/f", wdata, wstrb, e);
                        end
                    end
                end
                if (hs_ar) begin
                    checks++;
                    if (exp_ar.size() == 0) begin
                        failures++;
                        $display("FAIL ar_unexpected araddr=%h", araddr);
                    end else begin
                        e = exp_ar.pop_front();
                        if (araddr !== e || arprot !== 3'b000) begin
                            failures++;
                            $display("FAIL ar_addr got=%h/%0d expected=%h/0", araddr, arprot, e);
                        end
                    end
                end
                prev_awv = awvalid; prev_awa = awaddr;
                prev_wv  = wvalid;  prev_wd  = wdata;
            end else begin
                prev_awv = 1'b0;
                prev_wv  = 1'b0;
            end
        end
    end

    // AXI-Lite slave responder.
    initial begin
        int  aw_cnt, w_cnt;
        bit  got_aw, got_w, got_ar;
        aw_cnt = 0; w_cnt = 0;
        got_aw = 0; got_w = 0; got_ar = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                got_aw = 0; got_w = 0; got_ar = 0;
                aw_cnt = aw_delay; w_cnt = w_delay;
            end else begin
                if (hs_aw) begin
                    awready = 0; got_aw = 1;
                end else if (!awvalid) begin
                    aw_cnt = aw_delay;
                end else if (!awready) begin
                    if (aw_cnt <= 0) awready = 1;
                    else aw_cnt--;
                end
                if (hs_w) begin
                    wready = 0; got_w = 1;
                end else if (!wvalid) begin
                    w_cnt = w_delay;
                end else if (!wready) begin
                    if (w_cnt <= 0) wready = 1;
                    else w_cnt--;
                end
                if (hs_b) bvalid = 0;
                else if (got_aw && got_w && !bvalid) begin
                    bvalid = 1; bresp = bresp_cfg; got_aw = 0; got_w = 0;
                end
                if (hs_ar) begin
                    arready = 0; got_ar = 1;
                end else if (arvalid && !arready) arready = 1;
                if (hs_r) rvalid = 0;
                else if (got_ar && !rvalid) begin
                    rvalid = 1; rdata = rdata_cfg; rresp = rresp_cfg; got_ar = 0;
                end
            end
        end
    end

    // UART receiver for the bridge's replies.
    initial begin
        logic [7:0] b, e;
        int         st;
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                st = cyc;
                repeat (DIV / 2) @(negedge clk);
                checks++;
                if (tx !== 1'b0) begin
                    failures++;
                    $display("FAIL tx_start_bit got=%b expected=0", tx);
                end
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b[i] = tx;
                end
                repeat (DIV) @(negedge clk);
                checks++;
                if (tx !== 1'b1) begin
                    failures++;
                    $display("FAIL tx_stop_bit got=%b expected=1", tx);
                end
                tx_start.push_back(st);
                checks++;
                if (exp_tx.size() == 0) begin
                    failures++;
                    $display("FAIL tx_unexpected byte=%h", b);
                end else begin
                    e = exp_tx.pop_front();
                    if (b !== e) begin
                        failures++;
                        $display("FAIL tx_byte got=%h expected=%h", b, e);
                    end
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        wait_cyc(DIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cyc(DIV);
        end
        rx = stop;
        wait_cyc(DIV);
        rx = 1'b1;
    endtask

    task automatic send_write(input logic [31:0] a, input logic [31:0] d);
        send_byte(8'h57, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 1'b1);
        for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], 1'b1);
    endtask

    task automatic send_read(input logic [31:0] a);
        send_byte(8'h52, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 1'b1);
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        while ((exp_tx.size() != 0 || exp_aw.size() != 0 || exp_w.size() != 0 ||
                exp_ar.size() != 0 || busy) && n < budget) begin
            wait_cyc(1);
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s_timeout pending tx=%0d aw=%0d w=%0d ar=%0d busy=%b expected all 0",
                     name, exp_tx.size(), exp_aw.size(), exp_w.size(), exp_ar.size(), busy);
            exp_tx.delete(); exp_aw.delete(); exp_w.delete(); exp_ar.delete();
        end
        wait_cyc(2 * DIV);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_cyc(3);
        checks++;
        if ({awvalid, wvalid, bready, arvalid, rready, busy} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b expected=000000",
                     {awvalid, wvalid, bready, arvalid, rready, busy});
        end
        checks++;
        if (tx !== 1'b1) begin
            failures++;
            $display("FAIL reset_tx got=%b expected=1", tx);
        end
        checks++;
        if (awaddr !== 32'h0 || wdata !== 32'h0 || araddr !== 32'h0) begin
            failures++;
            $display("FAIL reset_regs got=%h/%h/%h expected=0", awaddr, wdata, araddr);
        end
        checks++;
        if (awprot !== 3'b000 || arprot !== 3'b000 || wstrb !== 4'hF) begin
            failures++;
            $display("FAIL reset_consts got=%0d/%0d/%h expected=0/0/f", awprot, arprot, wstrb);
        end
        rst_n = 1'b1;
        wait_cyc(4);
    endtask

    task automatic test_write();
        exp_aw.push_back(32'h4000_1000);
        exp_w.push_back(32'hDEAD_BEEF);
        exp_tx.push_back(8'hA0);
        send_write(32'h4000_1000, 32'hDEAD_BEEF);
        wait_done(2000, "write");
    endtask

    task automatic test_read();
        logic [7:0] rsp[5];
        rsp = '{8'hA0, 8'h78, 8'h56, 8'h34, 8'h12};
        rdata_cfg = 32'h1234_5678;
        tx_start.delete();
        exp_ar.push_back(32'h4000_1004);
        for (int i = 0; i < 5; i++) exp_tx.push_back(rsp[i]);
        send_read(32'h4000_1004);
        wait_done(2000, "read");
        checks++;
        if (tx_start.size() != 5) begin
            failures++;
            $display("FAIL read_tx_count got=%0d expected=5", tx_start.size());
        end else begin
            for (int i = 1; i < 5; i++) begin
                checks++;
                if (tx_start[i] - tx_start[i-1] != 10 * DIV) begin
                    failures++;
                    $display("FAIL read_tx_gap byte=%0d got=%0d expected=%0d",
                             i, tx_start[i] - tx_start[i-1], 10 * DIV);
                end
            end
        end
    endtask

    task automatic test_write_slow_err();
        aw_delay = 50;
        bresp_cfg = 2'b10;
        exp_aw.push_back(32'h4000_2008);
        exp_w.push_back(32'h0BAD_F00D);
        exp_tx.push_back(8'hA2);
        send_write(32'h4000_2008, 32'h0BAD_F00D);
        wait_done(2000, "write_err");
        aw_delay = 0;
        bresp_cfg = 2'b00;
    endtask

    task automatic test_ignore_and_framing();
        logic [7:0] rsp[5];
        send_byte(8'h33, 1'b1);
        wait_cyc(4 * DIV);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL ignore_busy got=%b expected=0", busy);
        end
        rsp = '{8'hA1, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
        rdata_cfg = 32'hCAFE_F00D;
        rresp_cfg = 2'b01;
        exp_ar.push_back(32'h4000_1004);
        for (int i = 0; i < 5; i++) exp_tx.push_back(rsp[i]);
        send_read(32'h4000_1007);
        wait_done(2000, "read_after_junk");
        rresp_cfg = 2'b00;
        send_byte(8'h57, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h10, 1'b0);
        wait_cyc(2 * DIV);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL framing_abort busy=%b expected=0", busy);
        end
        exp_aw.push_back(32'h4000_3000);
        exp_w.push_back(32'h1122_3344);
        exp_tx.push_back(8'hA0);
        send_write(32'h4000_3000, 32'h1122_3344);
        wait_done(2000, "write_after_frame_err");
    endtask

    task automatic test_timeout();
        logic saw_valid;
        send_byte(8'h57, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h10, 1'b1);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_inframe busy=%b expected=1", busy);
        end
        saw_valid = 1'b0;
        for (int i = 0; i < TO - 20; i++) begin
            wait_cyc(1);
            saw_valid |= awvalid | wvalid | arvalid;
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_early busy=%b expected=1", busy);
        end
        for (int i = 0; i < 120; i++) begin
            wait_cyc(1);
            saw_valid |= awvalid | wvalid | arvalid;
        end
        checks++;
        if (busy !== 1'b0 || saw_valid !== 1'b0) begin
            failures++;
            $display("FAIL timeout_abort busy=%b valid_seen=%b expected=0/0", busy, saw_valid);
        end
        rdata_cfg = 32'hA5A5_0001;
        exp_ar.push_back(32'h4000_0010);
        exp_tx.push_back(8'hA0);
        exp_tx.push_back(8'h01);
        exp_tx.push_back(8'h00);
        exp_tx.push_back(8'hA5);
        exp_tx.push_back(8'hA5);
        send_read(32'h4000_0010);
        wait_done(2000, "read_after_timeout");
    endtask

    task automatic test_reset_mid();
        int n;
        aw_delay = 100000;
        w_delay  = 100000;
        send_write(32'h4000_4000, 32'h0000_0001);
        n = 0;
        while (!awvalid && n < 100) begin
            wait_cyc(1);
            n++;
        end
        checks++;
        if (awvalid !== 1'b1 || wvalid !== 1'b1) begin
            failures++;
            $display("FAIL hang_valid got=%b%b expected=11", awvalid, wvalid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({awvalid, wvalid, bready, busy, tx} !== 5'b00001) begin
            failures++;
            $display("FAIL async_reset got=%b expected=00001", {awvalid, wvalid, bready, busy, tx});
        end
        wait_cyc(3);
        aw_delay = 0;
        w_delay  = 0;
        rst_n = 1'b1;
        wait_cyc(4);
        exp_aw.push_back(32'h4000_5000);
        exp_w.push_back(32'h55AA_55AA);
        exp_tx.push_back(8'hA0);
        send_write(32'h4000_5000, 32'h55AA_55AA);
        wait_done(2000, "write_after_reset");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_write_slow_err();
        test_ignore_and_framing();
        test_timeout();
        test_reset_mid();
        wait_cyc(20);
        checks++;
        if (exp_tx.size() != 0 || exp_aw.size() != 0 || exp_w.size() != 0 || exp_ar.size() != 0) begin
            failures++;
            $display("FAIL final_drain tx=%0d aw=%0d w=%0d ar=%0d expected=0",
                     exp_tx.size(), exp_aw.size(), exp_w.size(), exp_ar.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
